// File: rtl/keypad_time_decoder.sv
// Keypad-to-cook-time decoder: shifts BCD digits into MM:SS and runs the microwave countdown FSM.
// Optional build macro DONE_BEEP_EN adds a beep output that follows each completed countdown.
module keypad_time_decoder #(
    parameter int TICK_DIV = 7
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       key_err,
    output logic [1:0] dbg_state_o
`ifdef DONE_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic       is_digit, is_start, is_stop, is_bad;
    logic       tick, time_zero, dec_zero;
    logic [3:0] dmt, dmo, dst, dso;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_start  = key_valid && (key_code == 4'hA);
    assign is_stop   = key_valid && (key_code == 4'hB);
    assign is_bad    = key_valid && (key_code >= 4'hC);
    assign tick      = (state_q == S_RUN) && (presc_q == TICK_LAST);
    assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
    assign dec_zero  = ({dmt, dmo, dst, dso} == 16'h0000);

    // One-second BCD decrement; seconds above 59 simply count down through their own value.
    always_comb begin
        dmt = mt_q;
        dmo = mo_q;
        dst = st_q;
        dso = so_q;
        if (so_q != 4'd0) begin
            dso = so_q - 4'd1;
        end else if (st_q != 4'd0) begin
            dst = st_q - 4'd1;
            dso = 4'd9;
        end else begin
            dst = 4'd5;
            dso = 4'd9;
            if (mo_q != 4'd0) begin
                dmo = mo_q - 4'd1;
            end else begin
                dmo = 4'd9;
                dmt = mt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        err_d   = is_bad;

        // A STOP in RUN freezes the prescaler, so a suppressed tick is retried after resume.
        if (state_q == S_RUN && !is_stop) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (is_digit) begin
                    mt_d    = mo_q;
                    mo_d    = st_q;
                    st_d    = so_q;
                    so_d    = key_code;
                    state_d = S_ENTRY;
                end else if (is_start) begin
                    if (state_q == S_IDLE || time_zero) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end else if (is_stop && state_q == S_ENTRY) begin
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_stop) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    mt_d = dmt;
                    mo_d = dmo;
                    st_d = dst;
                    so_d = dso;
                    if (dec_zero) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PAUSE: begin
                if (is_start) begin
                    state_d = S_RUN;
                end else if (is_stop) begin
                    mt_d    = 4'd0;
                    mo_d    = 4'd0;
                    st_d    = 4'd0;
                    so_d    = 4'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign min_tens    = mt_q;
    assign min_ones    = mo_q;
    assign sec_tens    = st_q;
    assign sec_ones    = so_q;
    assign running     = (state_q == S_RUN);
    assign done        = done_q;
    assign key_err     = err_q;
    assign dbg_state_o = state_q;

`ifdef DONE_BEEP_EN
    localparam int BEEP_LEN = 3 * TICK_DIV;
    localparam int BW       = $clog2(BEEP_LEN);

    logic          beep_q, beep_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    // Counter holds the number of beep cycles still owed after the current one.
    always_comb begin
        beep_d = beep_q;
        bcnt_d = bcnt_q;
        if (done_d) begin
            beep_d = 1'b1;
            bcnt_d = BW'(BEEP_LEN - 1);
        end else if (beep_q) begin
            if (key_valid || bcnt_q == '0) begin
                beep_d = 1'b0;
            end else begin
                bcnt_d = bcnt_q - BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            beep_q <= 1'b0;
            bcnt_q <= '0;
        end else begin
            beep_q <= beep_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign beep = beep_q;
`endif

endmodule
